// File: rtl/cic_seq_ctrl.sv
// Session sequencer for the shared CIC decimator core: owns the core reset and
// input strobe, paces upstream samples, drops warm-up outputs, buffers results.
module cic_seq_ctrl #(
  parameter int NIN       = 12,
  parameter int NOUT      = 17,
  parameter int RATE_DIV  = 1,
  parameter int FLUSH_CYC = 4,
  parameter int WARMUP    = 3,
  parameter int DRAIN_CYC = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            stop,
  input  logic            in_valid,
  input  logic [NIN-1:0]  in_data,
  output logic            in_ready,
  output logic            core_rstn,
  output logic            core_en,
  output logic [NIN-1:0]  core_din,
  input  logic [NOUT-1:0] core_dout,
  input  logic            core_dout_valid,
  output logic            out_valid,
  output logic [NOUT-1:0] out_data,
  input  logic            out_ready,
  output logic            busy,
  output logic            ovf
);

  // Handshakes: a transfer happens in any cycle where valid and ready are both
  // high; valid never waits on ready, and data is stable while valid is high.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      phase_cnt_q, phase_cnt_d;
  logic [7:0]      pace_cnt_q, pace_cnt_d;
  logic [3:0]      warm_cnt_q, warm_cnt_d;
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [NOUT-1:0] mem0_q, mem0_d;
  logic [NOUT-1:0] mem1_q, mem1_d;
  logic            ovf_q, ovf_d;
  logic            core_rstn_q, core_rstn_d;
  logic            core_en_q, core_en_d;
  logic [NIN-1:0]  core_din_q, core_din_d;

  logic accept, pop, cap, keep;

  assign in_ready  = (state_q == S_RUN) && (pace_cnt_q == 8'd0);
  assign accept    = in_valid && in_ready;
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign cap       = ((state_q == S_RUN) || (state_q == S_DRAIN)) && core_dout_valid;
  assign keep      = cap && (warm_cnt_q == 4'd0);

  assign out_data  = mem0_q;
  assign busy      = (state_q != S_IDLE);
  assign ovf       = ovf_q;
  assign core_rstn = core_rstn_q;
  assign core_en   = core_en_q;
  assign core_din  = core_din_q;

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    pace_cnt_d  = pace_cnt_q;
    warm_cnt_d  = warm_cnt_q;
    fifo_cnt_d  = fifo_cnt_q;
    mem0_d      = mem0_q;
    mem1_d      = mem1_q;
    ovf_d       = ovf_q;
    core_rstn_d = core_rstn_q;
    core_en_d   = accept;
    core_din_d  = core_din_q;

    if (accept) begin
      core_din_d = in_data;
      pace_cnt_d = 8'(RATE_DIV - 1);
    end else if (pace_cnt_q != 8'd0) begin
      pace_cnt_d = pace_cnt_q - 8'd1;
    end

    if (cap && (warm_cnt_q != 4'd0)) warm_cnt_d = warm_cnt_q - 4'd1;

    // Shift-register FIFO: mem0 is always the head, a pop moves mem1 forward.
    case ({pop, keep})
      2'b10: begin
        mem0_d     = mem1_q;
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      2'b01: begin
        if (fifo_cnt_q == 2'd0) begin
          mem0_d     = core_dout;
          fifo_cnt_d = 2'd1;
        end else if (fifo_cnt_q == 2'd1) begin
          mem1_d     = core_dout;
          fifo_cnt_d = 2'd2;
        end else begin
          ovf_d = 1'b1;
        end
      end
      2'b11: begin
        if (fifo_cnt_q == 2'd1) begin
          mem0_d = core_dout;
        end else begin
          mem0_d = mem1_q;
          mem1_d = core_dout;
        end
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        core_rstn_d = 1'b1;
        if (start) begin
          state_d     = S_FLUSH;
          core_rstn_d = 1'b0;
          phase_cnt_d = 8'(FLUSH_CYC - 1);
          fifo_cnt_d  = 2'd0;
          mem0_d      = '0;
          mem1_d      = '0;
          ovf_d       = 1'b0;
          warm_cnt_d  = 4'(WARMUP);
          pace_cnt_d  = 8'd0;
        end
      end
      S_FLUSH: begin
        if (phase_cnt_q == 8'd0) begin
          state_d     = S_RUN;
          core_rstn_d = 1'b1;
        end else begin
          phase_cnt_d = phase_cnt_q - 8'd1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d     = S_DRAIN;
          phase_cnt_d = 8'(DRAIN_CYC - 1);
        end
      end
      S_DRAIN: begin
        if (phase_cnt_q == 8'd0) state_d = S_IDLE;
        else phase_cnt_d = phase_cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      phase_cnt_q <= 8'd0;
      pace_cnt_q  <= 8'd0;
      warm_cnt_q  <= 4'd0;
      fifo_cnt_q  <= 2'd0;
      mem0_q      <= '0;
      mem1_q      <= '0;
      ovf_q       <= 1'b0;
      core_rstn_q <= 1'b0;
      core_en_q   <= 1'b0;
      core_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      pace_cnt_q  <= pace_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      fifo_cnt_q  <= fifo_cnt_d;
      mem0_q      <= mem0_d;
      mem1_q      <= mem1_d;
      ovf_q       <= ovf_d;
      core_rstn_q <= core_rstn_d;
      core_en_q   <= core_en_d;
      core_din_q  <= core_din_d;
    end
  end

endmodule

// File: tb/tb_cic_seq_ctrl.sv
// Bench for cic_seq_ctrl: directed vector table, hand-written session corners,
// a RATE_DIV=4 pacing instance and randomized traffic against a queue model.
module tb_cic_seq_ctrl;

  localparam int NIN = 12, NOUT = 17;
  localparam int RATE = 1, FLUSH = 4, WARM = 3, DRAIN = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic            start, stop, in_valid, in_ready, core_rstn, core_en;
  logic [NIN-1:0]  in_data, core_din;
  logic [NOUT-1:0] core_dout, out_data;
  logic            core_dout_valid, out_valid, out_ready, busy, ovf;

  logic            s4_start, s4_stop, s4_in_valid, s4_in_ready, s4_core_rstn, s4_core_en;
  logic [NIN-1:0]  s4_in_data, s4_core_din;
  logic [NOUT-1:0] s4_core_dout, s4_out_data;
  logic            s4_cdv, s4_out_valid, s4_out_ready, s4_busy, s4_ovf;

  cic_seq_ctrl #(.NIN(NIN), .NOUT(NOUT), .RATE_DIV(RATE), .FLUSH_CYC(FLUSH),
                 .WARMUP(WARM), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_rstn(core_rstn), .core_en(core_en), .core_din(core_din),
    .core_dout(core_dout), .core_dout_valid(core_dout_valid),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .ovf(ovf)
  );

  cic_seq_ctrl #(.NIN(NIN), .NOUT(NOUT), .RATE_DIV(4), .FLUSH_CYC(FLUSH),
                 .WARMUP(WARM), .DRAIN_CYC(DRAIN)) dut4 (
    .clk(clk), .rstn(rstn), .start(s4_start), .stop(s4_stop),
    .in_valid(s4_in_valid), .in_data(s4_in_data), .in_ready(s4_in_ready),
    .core_rstn(s4_core_rstn), .core_en(s4_core_en), .core_din(s4_core_din),
    .core_dout(s4_core_dout), .core_dout_valid(s4_cdv),
    .out_valid(s4_out_valid), .out_data(s4_out_data), .out_ready(s4_out_ready),
    .busy(s4_busy), .ovf(s4_ovf)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // driver tasks
  task automatic idle_inputs();
    start = 0; stop = 0; in_valid = 0; in_data = '0;
    core_dout_valid = 0; core_dout = '0; out_ready = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  // scoreboard / reference model: session phase plus remaining cycles, FIFO as a queue
  localparam int M_IDLE = 0, M_FLUSH = 1, M_RUN = 2, M_DRAIN = 3;
  int m_st, m_left, m_pace, m_warm;
  logic m_ovf, m_crst, m_en;
  logic [NIN-1:0] m_din;
  logic [NOUT-1:0] exp_q[$];

  task automatic model_reset();
    m_st = M_IDLE; m_left = 0; m_pace = 0; m_warm = 0;
    m_ovf = 0; m_crst = 0; m_en = 0; m_din = '0;
    exp_q.delete();
  endtask

  function automatic bit model_ready();
    return (m_st == M_RUN) && (m_pace == 0);
  endfunction

  task automatic model_step();
    bit acc;
    acc = in_valid && model_ready();
    if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
    if ((m_st == M_RUN || m_st == M_DRAIN) && core_dout_valid) begin
      if (m_warm > 0) m_warm--;
      else if (exp_q.size() < 2) exp_q.push_back(core_dout);
      else m_ovf = 1;
    end
    m_en = acc;
    if (acc) begin
      m_din = in_data;
      m_pace = RATE - 1;
    end else if (m_pace > 0) m_pace--;
    case (m_st)
      M_IDLE: begin
        m_crst = 1;
        if (start) begin
          m_st = M_FLUSH; m_left = FLUSH; m_crst = 0;
          exp_q.delete(); m_ovf = 0; m_warm = WARM;
        end
      end
      M_FLUSH: begin
        m_left--;
        if (m_left == 0) begin m_st = M_RUN; m_crst = 1; end
      end
      M_RUN: if (stop) begin m_st = M_DRAIN; m_left = DRAIN; end
      default: begin
        m_left--;
        if (m_left == 0) m_st = M_IDLE;
      end
    endcase
  endtask

  typedef struct {
    logic st, sp, iv;
    logic [NIN-1:0] idata;
    logic cdv;
    logic [NOUT-1:0] cdout;
    logic ordy;
    logic e_rdy, e_crst, e_en, e_busy, e_ov, e_ovf;
    logic [NIN-1:0] e_din;
    logic [NOUT-1:0] e_dout;
  } vec_t;

  vec_t vt[16];

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    logic [NIN-1:0] d;
    bit r;
    int acc_n, last, rdy_n;

    vt[0]  = '{0,0,0,12'h0,0,17'h0,0,     0,1,0,0,0,0,12'h0,17'h0};
    vt[1]  = '{1,1,0,12'h0,0,17'h0,0,     0,0,0,1,0,0,12'h0,17'h0};
    vt[2]  = '{0,0,0,12'h0,0,17'h0,0,     0,0,0,1,0,0,12'h0,17'h0};
    vt[3]  = '{0,0,0,12'h0,0,17'h0,0,     0,0,0,1,0,0,12'h0,17'h0};
    vt[4]  = '{0,0,0,12'h0,0,17'h0,0,     0,0,0,1,0,0,12'h0,17'h0};
    vt[5]  = '{0,0,0,12'h0,0,17'h0,0,     1,1,0,1,0,0,12'h0,17'h0};
    vt[6]  = '{0,0,1,12'h5,0,17'h0,0,     1,1,1,1,0,0,12'h5,17'h0};
    vt[7]  = '{0,0,0,12'h0,1,17'h0AAAA,0, 1,1,0,1,0,0,12'h5,17'h0};
    vt[8]  = '{0,0,0,12'h0,1,17'h15555,0, 1,1,0,1,0,0,12'h5,17'h0};
    vt[9]  = '{0,0,0,12'h0,1,17'h00777,0, 1,1,0,1,0,0,12'h5,17'h0};
    vt[10] = '{0,0,0,12'h0,1,17'h01234,0, 1,1,0,1,1,0,12'h5,17'h01234};
    vt[11] = '{0,0,0,12'h0,1,17'h0BEEF,0, 1,1,0,1,1,0,12'h5,17'h01234};
    vt[12] = '{0,0,0,12'h0,1,17'h11111,0, 1,1,0,1,1,1,12'h5,17'h01234};
    vt[13] = '{0,0,0,12'h0,1,17'h02222,1, 1,1,0,1,1,1,12'h5,17'h0BEEF};
    vt[14] = '{0,1,1,12'h7,0,17'h0,0,     0,1,1,1,1,1,12'h7,17'h0BEEF};
    vt[15] = '{0,0,0,12'h0,0,17'h0,0,     0,1,0,1,1,1,12'h7,17'h0BEEF};

    idle_inputs();
    s4_start = 0; s4_stop = 0; s4_in_valid = 0; s4_in_data = '0;
    s4_cdv = 0; s4_core_dout = '0; s4_out_ready = 0;
    rstn = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_core_rstn", core_rstn, 0);
    chk("rst_core_en", core_en, 0);
    chk("rst_core_din", core_din, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    rstn = 1'b1;

    // table-driven session: start+stop together, flush, warmup, overflow, stop with accept
    for (int i = 0; i < 16; i++) begin
      start = vt[i].st; stop = vt[i].sp; in_valid = vt[i].iv; in_data = vt[i].idata;
      core_dout_valid = vt[i].cdv; core_dout = vt[i].cdout; out_ready = vt[i].ordy;
      tick();
      chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].e_rdy);
      chk($sformatf("v%0d_core_rstn", i), core_rstn, vt[i].e_crst);
      chk($sformatf("v%0d_core_en", i), core_en, vt[i].e_en);
      chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].e_ov);
      chk($sformatf("v%0d_ovf", i), ovf, vt[i].e_ovf);
      chk($sformatf("v%0d_core_din", i), core_din, vt[i].e_din);
      if (vt[i].e_ov) chk($sformatf("v%0d_out_data", i), out_data, vt[i].e_dout);
    end
    idle_inputs();

    // drain: pop once, capture one more output, then count remaining busy cycles
    out_ready = 1; tick(); out_ready = 0;
    chk("drain_pop_head", out_data, 17'h02222);
    core_dout_valid = 1; core_dout = 17'h0ABCD; tick(); core_dout_valid = 0;
    chk("drain_capture_valid", out_valid, 1);
    chk("drain_capture_head", out_data, 17'h02222);
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    chk("drain_busy_cycles", n, 13);
    chk("idle_fifo_kept", out_data, 17'h02222);
    chk("idle_ovf_sticky", ovf, 1);
    out_ready = 1; tick(); out_ready = 0;
    chk("idle_pop_second", out_data, 17'h0ABCD);
    chk("idle_pop_valid", out_valid, 1);

    // restart clears FIFO and ovf and repeats the flush
    start = 1; tick(); start = 0;
    chk("restart_fifo_clear", out_valid, 0);
    chk("restart_ovf_clear", ovf, 0);
    chk("restart_busy", busy, 1);
    n = 0;
    while (!core_rstn && n < 20) begin n++; tick(); end
    chk("restart_flush_len", n, FLUSH);
    chk("restart_in_ready", in_ready, 1);

    // asynchronous reset in RUN
    in_valid = 1; in_data = 12'h3C5; tick(); in_valid = 0;
    chk("pre_rst_core_en", core_en, 1);
    chk("pre_rst_core_din", core_din, 12'h3C5);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_core_rstn", core_rstn, 0);
    chk("async_rst_core_en", core_en, 0);
    chk("async_rst_core_din", core_din, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 0);
    tick(); rstn = 1'b1;

    // RATE_DIV=4 pacing on the second instance
    s4_start = 1; tick(); s4_start = 0;
    n = 0;
    while (!s4_in_ready && n < 20) begin tick(); n++; end
    chk("pace_run_reached", s4_in_ready, 1);
    s4_in_valid = 1;
    acc_n = 0; last = -100; rdy_n = 0;
    for (int c = 0; c < 40; c++) begin
      r = s4_in_ready;
      d = NIN'($urandom_range(0, 4095));
      s4_in_data = d;
      tick();
      if (r) begin
        acc_n++;
        if (acc_n > 1) chk("pace_gap", c - last, 4);
        last = c;
        chk("pace_core_din", s4_core_din, d);
      end
      chk("pace_core_en", s4_core_en, r);
    end
    s4_in_valid = 0;
    chk("pace_accepts", acc_n, 10);

    // randomized traffic against the reference model
    idle_inputs();
    do_reset();
    model_reset();
    for (int i = 0; i < 3000 && fails < 30; i++) begin
      chk("r_in_ready", in_ready, model_ready());
      chk("r_core_rstn", core_rstn, m_crst);
      chk("r_core_en", core_en, m_en);
      chk("r_core_din", core_din, m_din);
      chk("r_busy", busy, m_st != M_IDLE);
      chk("r_out_valid", out_valid, exp_q.size() != 0);
      chk("r_ovf", ovf, m_ovf);
      if (exp_q.size() != 0) chk("r_out_data", out_data, exp_q[0]);
      start = ($urandom_range(0, 39) == 0);
      stop = ($urandom_range(0, 29) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_data = NIN'($urandom_range(0, 4095));
      core_dout_valid = ($urandom_range(0, 9) < 3);
      core_dout = NOUT'($urandom_range(0, 131071));
      out_ready = ($urandom_range(0, 9) < 5);
      model_step();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
